pe_set_pingpong_loader: RTL and testbench
=========================================

# pe_set_pingpong_loader

Double-buffered (ping-pong) global-buffer loader sitting between the Y-bus and a NUM_ROW x NUM_COL PE set. It fills one bank from the load stream while the other bank drains onto the PE row bus. Each entry carries a row tag, matched against a programmable per-row tag table, plus a broadcast tag. It adds to the single-buffer PE-set loader: concurrent fill/drain, per-entry tagging, valid/ready backpressure and explicit bank status.

## Interface
- DATA_WIDTH, 16, entry payload width
- NUM_ROW, 4, PE rows addressed by tags (>=2)
- DEPTH, 512, entries per bank (power of two, >=4)
- TAG_W, $clog2(NUM_ROW)+1, tag width (one extension bit); all-ones = broadcast
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  load entry offered
- load_ready  out  1  loader accepts entry this cycle
- load_data  in  DATA_WIDTH  entry payload
- load_tag  in  TAG_W  entry destination tag
- load_last  in  1  closes current fill (sampled on accepted beat)
- tag_wr  in  1  program tag table
- tag_row  in  $clog2(NUM_ROW)  row index
- tag_val  in  TAG_W  tag for row
- tag_lock  out  1  tag table frozen (drain active)
- start  in  1  begin draining the oldest FULL bank
- bus_valid  out  1  entry on row bus
- bus_ready  in  1  all enabled rows accept
- bus_data  out  DATA_WIDTH  payload
- bus_row_en  out  NUM_ROW  rows whose table tag matches entry tag
- done  out  1  one-cycle pulse, bank fully drained
- full  out  1  no bank writable
- empty  out  1  both banks EMPTY
- busy  out  1  any bank FILLING or DRAINING

## Operation
- Per-bank state: EMPTY -> FILLING (first accepted beat) -> FULL (load_last accepted, or count reaches DEPTH) -> DRAINING (start accepted) -> EMPTY (last entry handed off).
- Write bank pointer wr_sel toggles on FILLING->FULL; read pointer rd_sel toggles on DRAINING->EMPTY. Banks are therefore filled and drained strictly in order.
- load_ready = bank[wr_sel] is EMPTY or FILLING, combinationally. Beat accepted on load_valid & load_ready; stores {load_tag, load_data} at wr_ptr, and wr_ptr/count increment.
- Bank count width $clog2(DEPTH)+1. At count == DEPTH the bank goes FULL regardless of load_last.
- start is honoured only if bank[rd_sel] is FULL and no bank is DRAINING; otherwise it is ignored with no side effect.
- Drain reads entries 0..count-1 in order. bus_row_en[r] = (entry tag == all-ones) or (tag_table[r] == entry tag).
- An entry with bus_row_en == 0 is dropped internally: it is never presented and costs one read slot.
- tag_wr is applied only when tag_lock = 0; while locked it is ignored. tag_lock = 1 while any bank is DRAINING.
- full = neither bank EMPTY nor FILLING at wr_sel (i.e. load_ready low). empty = both EMPTY. busy = any FILLING or DRAINING.
- Simultaneous fill completion of one bank and drain completion of the other in the same cycle: both transitions apply.
- Reset: both banks EMPTY, all pointers/counts 0, wr_sel = rd_sel = 0, tag_table[r] = r. Outputs: load_ready 1, bus_valid 0, bus_data 0, bus_row_en 0, done 0, tag_lock 0, full 0, empty 1, busy 0. Reset mid-fill or mid-drain discards all contents.

## Timing
- Bank RAM is one-cycle synchronous read. The output stage is a 2-entry skid register, so drain sustains 1 entry/cycle with bus_ready held high.
- start accepted in cycle t: first bus_valid in cycle t+2.
- bus_valid/bus_data/bus_row_en are stable while bus_valid & !bus_ready. They change only after a handshake.
- done pulses in the cycle after the final handshake (or the final dropped read). The bank reads EMPTY in that same cycle.
- The load path has zero latency. A write to bank X and a drain of bank Y proceed concurrently with no interaction.
- Tag table compare uses the table value registered at drain start; it is frozen by tag_lock.

## Test plan
- NUM_ROW=4, DEPTH=8. Load 3 entries with tags 0,1,2 plus load_last, then pulse start, with bus_ready=1. Required: bus_valid at start+2 for 3 consecutive cycles, bus_row_en 0001/0010/0100, then done; empty returns to 1.
- Load 8 entries without load_last. Required: bank 0 goes FULL on the 8th beat and load_ready stays 1 (bank 1 is EMPTY). Fill bank 1 the same way. Required: full=1 and load_ready=0 until the first drain's done.
- Drain bank 0 while filling bank 1 concurrently, with bus_ready toggling 1,0,1,0. Required: no data loss or duplication, order preserved, and bus outputs held stable during stalls.
- tag_wr row2 := 5 before start; tag_wr row2 := 1 during drain. Required: entry tag 5 gives row_en 0100; the second write is ignored. Entry tag 7 (broadcast) gives 1111; entry tag 6 is dropped with no bus_valid.
- start with no FULL bank, and a second start mid-drain. Required: both are ignored, state is unchanged, and no extra done pulse occurs.
- Assert rst mid-drain (after 2 of 5 handshakes). Required: next cycle bus_valid=0, empty=1, load_ready=1, tag_table restored to 0,1,2,3.

Source files
------------

// File: rtl/pe_set_pingpong_loader.sv
`default_nettype none
// ============================================================================
// Module   : pe_set_pingpong_loader
// Purpose  : Double-buffered global-buffer loader. One bank fills from the
//            load stream while the other drains onto the PE row bus. Each
//            entry carries a row tag matched against a per-row tag table.
// Revision : 1.0 - initial release
// ============================================================================
module pe_set_pingpong_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROW    = 4,
    parameter int DEPTH      = 512,
    parameter int TAG_W      = $clog2(NUM_ROW) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [DATA_WIDTH-1:0]      load_data,
    input  logic [TAG_W-1:0]           load_tag,
    input  logic                       load_last,
    input  logic                       tag_wr,
    input  logic [$clog2(NUM_ROW)-1:0] tag_row,
    input  logic [TAG_W-1:0]           tag_val,
    output logic                       tag_lock,
    input  logic                       start,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [DATA_WIDTH-1:0]      bus_data,
    output logic [NUM_ROW-1:0]         bus_row_en,
    output logic                       done,
    output logic                       full,
    output logic                       empty,
    output logic                       busy
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = TAG_W + DATA_WIDTH;

    localparam logic [1:0] c_ST_EMPTY    = 2'd0;
    localparam logic [1:0] c_ST_FILLING  = 2'd1;
    localparam logic [1:0] c_ST_FULL     = 2'd2;
    localparam logic [1:0] c_ST_DRAINING = 2'd3;

    localparam logic [TAG_W-1:0] c_BCAST = {TAG_W{1'b1}};

    // Bank bookkeeping
    logic [1:0]        r_state [2];
    logic [c_CW-1:0]   r_count [2];
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [c_CW-1:0]   r_rd_ptr;
    logic [TAG_W-1:0]  r_tag_table [NUM_ROW];
    logic              r_done;

    // Both banks share one storage array, bank select is the address MSB
    logic [c_EW-1:0]   r_mem [2*DEPTH];
    logic              r_ram_vld;
    logic [c_EW-1:0]   r_ram_q;

    // Two-entry skid buffer behind the RAM output register
    logic [DATA_WIDTH-1:0] r_sk_data [2];
    logic [NUM_ROW-1:0]    r_sk_en   [2];
    logic [1:0]            r_sk_cnt;

    logic [1:0]        w_state_nxt [2];
    logic [c_CW-1:0]   w_count_nxt [2];

    logic              w_any_drain;
    logic              w_draining;
    logic              w_accept;
    logic              w_fill_close;
    logic              w_start_ok;
    logic [c_CW-1:0]   w_wr_cnt;
    logic [c_AW:0]     w_wr_addr;
    logic [c_AW:0]     w_rd_addr;

    logic [TAG_W-1:0]      w_ram_tag;
    logic [DATA_WIDTH-1:0] w_ram_data;
    logic [NUM_ROW-1:0]    w_ram_en;
    logic                  w_ram_live;
    logic                  w_sk_vld;
    logic                  w_pop;
    logic                  w_pop_sk;
    logic                  w_push;
    logic                  w_sk_wr_idx;
    logic [1:0]            w_sk_cnt_nxt;
    logic                  w_issue;
    logic                  w_finish;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    assign load_ready   = (r_state[r_wr_sel] == c_ST_EMPTY) ||
                          (r_state[r_wr_sel] == c_ST_FILLING);
    assign w_accept     = load_valid && load_ready;
    assign w_wr_cnt     = r_count[r_wr_sel];
    assign w_wr_addr    = {r_wr_sel, w_wr_cnt[c_AW-1:0]};
    assign w_fill_close = w_accept &&
                          (load_last || (w_wr_cnt == c_CW'(DEPTH - 1)));

    // ------------------------------------------------------------------
    // Drain side: banks drain in order, so only bank[rd_sel] can drain
    // ------------------------------------------------------------------
    assign w_any_drain = (r_state[0] == c_ST_DRAINING) ||
                         (r_state[1] == c_ST_DRAINING);
    assign w_draining  = (r_state[r_rd_sel] == c_ST_DRAINING);
    assign w_start_ok  = start && (r_state[r_rd_sel] == c_ST_FULL) && !w_any_drain;
    assign w_rd_addr   = {r_rd_sel, r_rd_ptr[c_AW-1:0]};

    assign w_ram_tag  = r_ram_q[c_EW-1 -: TAG_W];
    assign w_ram_data = r_ram_q[DATA_WIDTH-1:0];

    for (genvar g = 0; g < NUM_ROW; g++) begin : g_row_match
        assign w_ram_en[g] = (w_ram_tag == c_BCAST) || (r_tag_table[g] == w_ram_tag);
    end

    // A RAM word with no matching row is consumed here and never presented
    assign w_ram_live = r_ram_vld && (|w_ram_en);
    assign w_sk_vld   = (r_sk_cnt != 2'd0);

    // Skid head has priority; an empty skid lets the RAM word bypass to the bus
    assign bus_valid  = w_sk_vld || w_ram_live;
    assign bus_data   = w_sk_vld ? r_sk_data[0] : (w_ram_live ? w_ram_data : '0);
    assign bus_row_en = w_sk_vld ? r_sk_en[0]   : (w_ram_live ? w_ram_en   : '0);

    assign w_pop        = bus_valid && bus_ready;
    assign w_pop_sk     = w_pop && w_sk_vld;
    assign w_push       = w_ram_live && !(w_pop && !w_sk_vld);
    assign w_sk_cnt_nxt = r_sk_cnt + {1'b0, w_push} - {1'b0, w_pop_sk};
    assign w_sk_wr_idx  = (r_sk_cnt != 2'd0) && !w_pop_sk;

    // Only read when the word landing next cycle is guaranteed a skid slot
    assign w_issue  = w_draining && (r_rd_ptr != r_count[r_rd_sel]) && (w_sk_cnt_nxt < 2'd2);
    // Everything read and nothing left in flight after this cycle
    assign w_finish = w_draining && (r_rd_ptr == r_count[r_rd_sel]) &&
                      (w_sk_cnt_nxt == 2'd0) && (r_ram_vld || w_sk_vld);

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign tag_lock = w_any_drain;
    assign full     = !load_ready;
    assign empty    = (r_state[0] == c_ST_EMPTY) && (r_state[1] == c_ST_EMPTY);
    assign busy     = (r_state[0] == c_ST_FILLING) || (r_state[1] == c_ST_FILLING) || w_any_drain;
    assign done     = r_done;

    // Per-bank next state; fill and drain never target the same bank
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            w_count_nxt[b] = r_count[b];
            if (w_accept && (r_wr_sel == 1'(b))) begin
                w_count_nxt[b] = r_count[b] + 1'b1;
                w_state_nxt[b] = w_fill_close ? c_ST_FULL : c_ST_FILLING;
            end
            if (w_start_ok && (r_rd_sel == 1'(b))) begin
                w_state_nxt[b] = c_ST_DRAINING;
            end
            if (w_finish && (r_rd_sel == 1'(b))) begin
                w_state_nxt[b] = c_ST_EMPTY;
                w_count_nxt[b] = '0;
            end
        end
    end

    // Bank state, pointers, tag table and drain control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= c_ST_EMPTY;
                r_count[b] <= '0;
            end
            for (int r = 0; r < NUM_ROW; r++) begin
                r_tag_table[r] <= TAG_W'(r);
            end
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= w_state_nxt[b];
                r_count[b] <= w_count_nxt[b];
            end
            if (tag_wr && !w_any_drain && (int'(tag_row) < NUM_ROW)) begin
                r_tag_table[tag_row] <= tag_val;
            end
            if (w_fill_close) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_finish) begin
                r_rd_sel <= ~r_rd_sel;
            end
            if (w_start_ok) begin
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_vld <= w_issue;
            r_done    <= w_finish;
        end
    end

    // Bank storage: one write port (fill), one synchronous read port (drain)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= {load_tag, load_data};
        end
        if (w_issue) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    // Skid buffer: shift on pop, append live RAM words that cannot bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sk_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_sk_data[i] <= '0;
                r_sk_en[i]   <= '0;
            end
        end else begin
            r_sk_cnt <= w_sk_cnt_nxt;
            if (w_pop_sk) begin
                r_sk_data[0] <= r_sk_data[1];
                r_sk_en[0]   <= r_sk_en[1];
            end
            if (w_push) begin
                if (w_sk_wr_idx) begin
                    r_sk_data[1] <= w_ram_data;
                    r_sk_en[1]   <= w_ram_en;
                end else begin
                    r_sk_data[0] <= w_ram_data;
                    r_sk_en[0]   <= w_ram_en;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_set_pingpong_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_set_pingpong_loader
// Purpose  : Scoreboard bench for the ping-pong PE-set loader. A queue-based
//            reference model predicts bank status and bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_set_pingpong_loader;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int DP = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_data = '0;
    logic [TW-1:0] load_tag = '0;
    logic          load_last = 1'b0;
    logic          tag_wr = 1'b0;
    logic [1:0]    tag_row = '0;
    logic [TW-1:0] tag_val = '0;
    logic          tag_lock;
    logic          start = 1'b0;
    logic          bus_valid;
    logic          bus_ready = 1'b1;
    logic [DW-1:0] bus_data;
    logic [NR-1:0] bus_row_en;
    logic          done;
    logic          full;
    logic          empty;
    logic          busy;

    pe_set_pingpong_loader #(
        .DATA_WIDTH(DW), .NUM_ROW(NR), .DEPTH(DP), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_tag(load_tag), .load_last(load_last),
        .tag_wr(tag_wr), .tag_row(tag_row), .tag_val(tag_val), .tag_lock(tag_lock),
        .start(start), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_data(bus_data), .bus_row_en(bus_row_en), .done(done),
        .full(full), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NR-1:0] en;
    } exp_t;

    // Reference model: entries in arrival order, closed-bank lengths in order
    exp_t            sb[$];
    logic [TW+DW-1:0] mdl_entries[$];
    int              closed_len[$];
    int              cur_len = 0;
    bit              mdl_draining = 0;
    int              mtag[NR];
    bit              drain_last_kept = 0;
    int              exp_first_cyc = -1;
    int              hs_count = 0;
    int              cyc = 0;
    int              br_mode = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [NR-1:0] exp_row_en(input logic [TW-1:0] tag);
        logic [NR-1:0] m;
        m = '0;
        for (int r = 0; r < NR; r++)
            if (tag == {TW{1'b1}} || mtag[r] == int'(tag)) m[r] = 1'b1;
        return m;
    endfunction

    task automatic mdl_reset();
        sb.delete();
        mdl_entries.delete();
        closed_len.delete();
        cur_len = 0;
        mdl_draining = 0;
        exp_first_cyc = -1;
        for (int r = 0; r < NR; r++) mtag[r] = r;
    endtask

    // bus_ready pattern: 0 = held high, 1 = toggling, 2 = random
    initial begin
        forever begin
            @(posedge clk); #1;
            case (br_mode)
                0:       bus_ready = 1'b1;
                1:       bus_ready = ~bus_ready;
                default: bus_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every presented entry with the scoreboard head
    initial begin
        bit exp_done;
        exp_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_done = 0;
            end else begin
                if (exp_done) begin
                    cmp("done_after_last_handshake", done, 1'b1);
                    exp_done = 0;
                end
                if (done) begin
                    cmp("done_while_draining", mdl_draining, 1'b1);
                    cmp("done_with_entries_left", sb.size(), 0);
                    if (mdl_draining) begin
                        mdl_draining = 0;
                        void'(closed_len.pop_front());
                    end
                end
                if (exp_first_cyc == cyc) begin
                    cmp("first_valid_latency", bus_valid, 1'b1);
                    exp_first_cyc = -1;
                end
                if (bus_valid) begin
                    if (sb.size() == 0) begin
                        cmp("unexpected_bus_valid", bus_valid, 1'b0);
                    end else begin
                        cmp("bus_data", bus_data, sb[0].data);
                        cmp("bus_row_en", bus_row_en, sb[0].en);
                        if (bus_ready) begin
                            void'(sb.pop_front());
                            hs_count++;
                            if (sb.size() == 0 && drain_last_kept) exp_done = 1;
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus; status is checked against the model before it
    // absorbs this cycle's accepted actions
    task automatic step(input bit lv, input logic [DW-1:0] ld, input logic [TW-1:0] lt,
                        input bit ll, input bit st, input bit tw, input int trow,
                        input logic [TW-1:0] tv, input bit rs);
        @(posedge clk); #1;
        load_valid = lv; load_data = ld; load_tag = lt; load_last = ll;
        start = st; tag_wr = tw; tag_row = 2'(trow); tag_val = tv; rst = rs;
        @(negedge clk); #1;
        if (rs) begin
            mdl_reset();
        end else begin
            cmp("load_ready", load_ready, closed_len.size() < 2);
            cmp("full", full, closed_len.size() == 2);
            cmp("empty", empty, closed_len.size() == 0 && cur_len == 0);
            cmp("busy", busy, cur_len > 0 || mdl_draining);
            cmp("tag_lock", tag_lock, mdl_draining);
            if (tw && !mdl_draining) mtag[trow] = int'(tv);
            if (st && !mdl_draining && closed_len.size() > 0) begin
                int n;
                n = closed_len[0];
                mdl_draining = 1;
                drain_last_kept = 0;
                for (int i = 0; i < n; i++) begin
                    logic [TW+DW-1:0] e;
                    exp_t x;
                    e = mdl_entries.pop_front();
                    x.data = e[DW-1:0];
                    x.en = exp_row_en(e[TW+DW-1:DW]);
                    drain_last_kept = (x.en != '0);
                    if (x.en != '0) begin
                        sb.push_back(x);
                        if (i == 0) exp_first_cyc = cyc + 2;
                    end
                end
            end
            if (lv && closed_len.size() < 2) begin
                mdl_entries.push_back({lt, ld});
                cur_len++;
                if (ll || cur_len == DP) begin
                    closed_len.push_back(cur_len);
                    cur_len = 0;
                end
            end
        end
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic load(input logic [TW-1:0] tag, input bit last);
        step(1, DW'($urandom), tag, last, 0, 0, 0, '0, 0);
    endtask

    task automatic kick();
        step(0, '0, '0, 0, 1, 0, 0, '0, 0);
    endtask

    task automatic chk_bus_idle();
        cmp("idle_bus_valid", bus_valid, 1'b0);
        cmp("idle_bus_data", bus_data, '0);
        cmp("idle_bus_row_en", bus_row_en, '0);
        cmp("idle_done", done, 1'b0);
    endtask

    // Run until the model's drain completes, optionally loading in parallel
    task automatic run_drain(input bit with_loads, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            if (!mdl_draining) return;
            if (with_loads)
                step(1'($urandom_range(0, 1)), DW'($urandom), TW'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0), 0, 0, 0, '0, 0);
            else
                idle();
        end
        if (mdl_draining) cmp("drain_timeout", 1'b1, 1'b0);
    endtask

    task automatic flush();
        for (int k = 0; k < 6; k++) begin
            if (cur_len > 0 && closed_len.size() < 2) load(TW'($urandom_range(0, 7)), 1);
            if (!mdl_draining && closed_len.size() > 0) kick();
            run_drain(0, 100);
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) mtag[r] = r;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_reset();
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        idle();
        chk_bus_idle();

        // Short bank: three tagged entries closed by load_last
        load(3'd0, 0); load(3'd1, 0); load(3'd2, 1);
        kick();
        run_drain(0, 40);
        idle();

        // Two banks closed by count, then drain with toggling ready while filling
        for (int i = 0; i < 16; i++) load(TW'($urandom_range(0, 3)), 0);
        for (int i = 0; i < 3; i++) load(3'd1, 0);
        br_mode = 1;
        step(1, DW'($urandom), 3'd2, 0, 1, 0, 0, '0, 0);
        run_drain(1, 80);
        step(1, DW'($urandom), 3'd3, 0, 1, 0, 0, '0, 0);
        run_drain(1, 80);
        flush();
        br_mode = 0;

        // Tag table programming and lock
        step(0, '0, '0, 0, 0, 1, 2, 3'd5, 0);
        load(3'd5, 0); load(3'd7, 0); load(3'd6, 0); load(3'd0, 1);
        kick();
        step(0, '0, '0, 0, 0, 1, 2, 3'd1, 0);
        run_drain(0, 40);

        // Ignored starts: nothing full, and a second start mid-drain
        kick();
        idle();
        for (int i = 0; i < 4; i++) load(TW'($urandom_range(0, 7)), i == 3);
        load(3'd7, 0); load(3'd1, 1);
        kick();
        idle();
        kick();
        run_drain(0, 40);
        flush();

        // Reset in the middle of a five-entry drain
        for (int i = 0; i < 5; i++) load(TW'(i % 4), i == 4);
        hs_count = 0;
        kick();
        for (int k = 0; k < 20 && hs_count < 2; k++) idle();
        cmp("reset_wait_handshakes", hs_count >= 2, 1'b1);
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        idle();
        chk_bus_idle();
        for (int i = 0; i < 4; i++) load(TW'(i), i == 3);
        kick();
        run_drain(0, 40);

        // Randomised traffic
        br_mode = 2;
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), DW'($urandom), TW'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 3),
                 TW'($urandom_range(0, 7)), 0);
        end
        flush();
        idle();
        idle();
        cmp("scoreboard_drained", sb.size(), 0);
        cmp("final_empty", empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
